// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, registered instruction
// output to decode, PC redirects from branch/jump resolution take priority.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  // state  | meaning
  // S_REQ  | presenting a fetch request at pc
  // S_WAIT | request accepted, waiting for the response (drop marks it stale)
  // S_HOLD | instruction presented to decode until accepted
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic        inst_valid_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req_valid   = (state == S_REQ);
  assign imem_req_addr    = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP;
      inst_pc    <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop       <= drop_nxt;
      inst_valid <= inst_valid_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drop_nxt       = drop;
    inst_valid_nxt = inst_valid;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;

    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_aligned;
          if (imem_req_ready) begin
            // the request just accepted carries the old pc; drop its response
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
          drop_nxt  = 1'b0;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_aligned;
          if (imem_rsp_valid) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt      = S_HOLD;
            inst_nxt       = imem_rsp_data;
            inst_pc_nxt    = pc;
            inst_valid_nxt = 1'b1;
            pc_nxt         = pc + 32'd4;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt         = redirect_aligned;
          inst_valid_nxt = 1'b0;
          state_nxt      = S_REQ;
        end else if (inst_ready) begin
          inst_valid_nxt = 1'b0;
          state_nxt      = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the single-issue RV32 NPC core.
- Sits directly upstream of the decode/ALU-control stage and supplies it with the 32-bit instruction word it decodes.
- Holds the PC and issues one fetch at a time to instruction memory over a valid/ready request plus valid response interface.
- Presents each fetched instruction with its PC to decode on a valid/ready handshake, and accepts PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  fetch address, word aligned.
- imem_rsp_valid  input  1  response data valid (single cycle).
- imem_rsp_data  input  32  fetched instruction word.
- inst_valid  output  1  inst/inst_pc valid to decode.
- inst_ready  input  1  decode accepts instruction.
- inst  output  32  instruction word to decode.
- inst_pc  output  32  PC of inst.
- redirect_valid  input  1  load new PC (branch taken/jal/jalr).
- redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0.

Behaviour:
- Reset (async, immediate): state=REQ, pc=RESET_PC, drop=0, inst_valid=0, inst=32'h0000_0013 (nop), inst_pc=0.
- Outputs are registered, except imem_req_valid=(state==REQ) and imem_req_addr=pc, which decode state/registers only. No combinational path from any input to any output.
- At most one request outstanding. Memory latency ≥1 cycle after acceptance; it is arbitrary.
- States:
  - REQ: imem_req_valid=1. On valid&ready, go to WAIT.
  - WAIT: waiting for response. On imem_rsp_valid with drop=0: inst<=rsp_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4, go to HOLD. On imem_rsp_valid with drop=1: discard data, drop<=0, go to REQ.
  - HOLD: inst_valid=1. inst and inst_pc stay stable until accepted. On inst_ready: inst_valid<=0, go to REQ. A new request is issued the cycle after acceptance.
- Redirect has the highest priority in every state. It updates pc<=redirect_pc & ~3 on the same edge.
  - REQ, no handshake that cycle: stay in REQ; the next request uses the new pc.
  - REQ, handshake in the same cycle: go to WAIT with drop<=1. The in-flight stale response is discarded.
  - WAIT, no response that cycle: drop<=1.
  - WAIT, response in the same cycle: discard the response, go to REQ.
  - HOLD: inst_valid<=0 and go to REQ, even if inst_ready=1 that cycle. The held instruction is treated as consumed or killed; decode owns that distinction.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- imem_rsp_valid outside WAIT is ignored.
- Reset asserted mid-transaction aborts everything. Any response arriving after reset release, before a new request is accepted, is ignored (state is REQ).
- Throughput: one instruction per 3 cycles minimum (REQ, WAIT with 1-cycle latency, HOLD with immediate ready).

Test Plan:
- Reset/boot: release rst, ready=1, 1-cycle memory returning 32'h0000_0513 -> first imem_req_addr=32'h8000_0000; inst_valid rises 2 cycles after the request with inst=32'h0000_0513, inst_pc=32'h8000_0000; next request addr=32'h8000_0004.
- Backpressure: hold inst_ready=0 for 5 cycles -> inst/inst_pc constant, imem_req_valid=0 throughout; raise ready -> inst_valid drops next cycle, new request at pc+4.
- Request stall: imem_req_ready=0 for 4 cycles -> imem_req_valid and addr stay stable at 32'h8000_0008; no state advance.
- Redirect in WAIT: request to 32'h8000_000C accepted, redirect_pc=32'h8000_0102 before response -> that response dropped, inst_valid stays 0, next request addr=32'h8000_0100.
- Redirect in HOLD with inst_ready=1 same cycle -> inst_valid=0 next cycle, next request addr=redirect target; no duplicate instruction presented.
- Wrap and async reset: redirect to 32'hFFFF_FFFC, fetch completes -> next addr 32'h0000_0000; assert rst mid-WAIT, then release -> addr returns to 32'h8000_0000, late response ignored.
